simple_spi_s_bit_rw: RTL and testbench

//   SPI slave (mode 0: CPOL=0, CPHA=0), the responder end of the team's SPI master link.

---
 rtl/simple_spi_s_bit_rw.sv | 145 ++++++++++++++
 tb/tb_simple_spi_s_bit_rw.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/simple_spi_s_bit_rw.sv
// SPI mode-0 slave: oversampled in sys_clk, full-duplex MSB-first frame of t_size bits.
// Optional SPI_S_OVERRUN_EN: read_en becomes a level acknowledged by rd_ack, with sticky overrun.
module simple_spi_s_bit_rw #(
    parameter int unsigned W      = 8,
    parameter int unsigned SIZE_W = 4
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic [SIZE_W-1:0] t_size,
    input  logic [W-1:0]      d_in,
    output logic [W-1:0]      d_out,
    output logic              read_en,
    output logic              busy
`ifdef SPI_S_OVERRUN_EN
    ,
    input  logic              rd_ack,
    output logic              overrun
`endif
);

    localparam int unsigned CW = $clog2(W + 1);
    localparam int unsigned IW = $clog2(W);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e         state;
    logic           sclk_meta, s_sclk, s_sclk_d;
    logic           cs_meta, s_cs;
    logic           mosi_meta, s_mosi;
    logic [W-1:0]   tx_sh, rx_sh;
    logic [CW-1:0]  cnt, n_lat;

    logic           rise, fall, last_bit;
    logic [CW-1:0]  n_new;
    logic [IW-1:0]  first_idx, next_idx;
    logic [W-1:0]   rx_next;

    always_comb begin
        rise = s_sclk & ~s_sclk_d;
        fall = ~s_sclk & s_sclk_d;
        if (t_size == '0 || 32'(t_size) > W) begin
            n_new = CW'(W);
        end else begin
            n_new = CW'(t_size);
        end
        first_idx = IW'(n_new - CW'(1));
        next_idx  = IW'(n_lat - CW'(1) - cnt);
        rx_next   = {rx_sh[W-2:0], s_mosi};
        last_bit  = (cnt == n_lat - CW'(1));
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            sclk_meta <= 1'b0;
            s_sclk    <= 1'b0;
            s_sclk_d  <= 1'b0;
            cs_meta   <= 1'b1;
            s_cs      <= 1'b1;
            mosi_meta <= 1'b0;
            s_mosi    <= 1'b0;
            state     <= StIdle;
            tx_sh     <= '0;
            rx_sh     <= '0;
            cnt       <= '0;
            n_lat     <= '0;
            miso      <= 1'b0;
            d_out     <= '0;
            read_en   <= 1'b0;
            busy      <= 1'b0;
`ifdef SPI_S_OVERRUN_EN
            overrun   <= 1'b0;
`endif
        end else begin
            sclk_meta <= spi_clk;
            s_sclk    <= sclk_meta;
            s_sclk_d  <= s_sclk;
            cs_meta   <= cs;
            s_cs      <= cs_meta;
            mosi_meta <= mosi;
            s_mosi    <= mosi_meta;

`ifdef SPI_S_OVERRUN_EN
            if (rd_ack) begin
                read_en <= 1'b0;
                overrun <= 1'b0;
            end
`else
            read_en <= 1'b0;
`endif

            // A released chip select overrides any edge seen in the same cycle.
            if (s_cs) begin
                state <= StIdle;
                miso  <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        n_lat <= n_new;
                        tx_sh <= d_in;
                        rx_sh <= '0;
                        cnt   <= '0;
                        miso  <= d_in[first_idx];
                        busy  <= 1'b1;
                        state <= StShift;
                    end
                    StShift: begin
                        if (rise) begin
                            rx_sh <= rx_next;
                            cnt   <= cnt + CW'(1);
                            if (last_bit) begin
`ifdef SPI_S_OVERRUN_EN
                                // Unacknowledged word is kept; the new one is dropped.
                                if (read_en && !rd_ack) begin
                                    overrun <= 1'b1;
                                end else begin
                                    d_out   <= rx_next;
                                    read_en <= 1'b1;
                                end
`else
                                d_out   <= rx_next;
                                read_en <= 1'b1;
`endif
                                state <= StDone;
                            end
                        end else if (fall && cnt != '0) begin
                            miso <= tx_sh[next_idx];
                        end
                    end
                    StDone: begin
                        state <= StDone;
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_simple_spi_s_bit_rw.sv
// Loopback bench for simple_spi_s_bit_rw: behavioural mode-0 master, spi_clk = sys_clk/8.
// Build with SPI_S_OVERRUN_EN defined to also exercise the overrun path.
module tb_simple_spi_s_bit_rw;

    logic       sys_clk = 1'b0;
    logic       rst;
    logic       spi_clk;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic [3:0] t_size;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       read_en;
    logic       busy;
`ifdef SPI_S_OVERRUN_EN
    logic       rd_ack;
    logic       overrun;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int re_cnt = 0;
    logic re_prev = 1'b0;
    logic [7:0] m_rx;
    logic [2:0] m_ex;
    int base;

    simple_spi_s_bit_rw #(
        .W      (8),
        .SIZE_W (4)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .spi_clk (spi_clk),
        .cs      (cs),
        .mosi    (mosi),
        .miso    (miso),
        .t_size  (t_size),
        .d_in    (d_in),
        .d_out   (d_out),
        .read_en (read_en),
        .busy    (busy)
`ifdef SPI_S_OVERRUN_EN
        ,
        .rd_ack  (rd_ack),
        .overrun (overrun)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    // Count rising edges of read_en, sampled away from the active edge.
    always @(negedge sys_clk) begin
        if (read_en === 1'b1 && re_prev !== 1'b1) re_cnt++;
        re_prev = read_en;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Master frame: nbits of tx, cs released after stop_after bits plus extra clock pulses.
    task automatic spi_xfer(input int nbits, input int stop_after, input int extra,
                            input logic [7:0] tx, input bit ack);
        m_rx = '0;
        m_ex = '0;
        @(negedge sys_clk);
        cs   = 1'b0;
        mosi = tx[nbits-1];
        repeat (8) @(negedge sys_clk);
        for (int i = 0; i < stop_after; i++) begin
            m_rx    = {m_rx[6:0], miso};
            spi_clk = 1'b1;
            repeat (4) @(negedge sys_clk);
            spi_clk = 1'b0;
            if (i < nbits - 1) mosi = tx[nbits-2-i];
            repeat (4) @(negedge sys_clk);
        end
        for (int j = 0; j < extra; j++) begin
            mosi    = 1'b1;
            m_ex    = {m_ex[1:0], miso};
            spi_clk = 1'b1;
            repeat (4) @(negedge sys_clk);
            spi_clk = 1'b0;
            repeat (4) @(negedge sys_clk);
        end
        cs   = 1'b1;
        mosi = 1'b0;
        repeat (6) @(negedge sys_clk);
`ifdef SPI_S_OVERRUN_EN
        if (ack) begin
            rd_ack = 1'b1;
            @(negedge sys_clk);
            rd_ack = 1'b0;
            @(negedge sys_clk);
        end
`else
        if (ack) @(negedge sys_clk);
`endif
    endtask

    initial begin
        rst     = 1'b1;
        spi_clk = 1'b0;
        cs      = 1'b1;
        mosi    = 1'b0;
        t_size  = 4'd8;
        d_in    = 8'h00;
`ifdef SPI_S_OVERRUN_EN
        rd_ack  = 1'b0;
`endif
        repeat (3) @(negedge sys_clk);
        rst = 1'b0;
        @(negedge sys_clk);
        check_eq("rst_miso", 32'(miso), 32'd0);
        check_eq("rst_d_out", 32'(d_out), 32'h00);
        check_eq("rst_read_en", 32'(read_en), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);

        // Full 8-bit frame
        t_size = 4'd8;
        d_in   = 8'hA5;
        base   = re_cnt;
        spi_xfer(8, 8, 0, 8'h3C, 1'b1);
        check_eq("f8_master_rx", 32'(m_rx), 32'hA5);
        check_eq("f8_d_out", 32'(d_out), 32'h3C);
        check_eq("f8_pulses", 32'(re_cnt - base), 32'd1);
        check_eq("f8_busy_after", 32'(busy), 32'd0);

        // Reset in the middle of a frame
        d_in = 8'hFF;
        cs   = 1'b0;
        repeat (10) @(negedge sys_clk);
        check_eq("mid_busy", 32'(busy), 32'd1);
        check_eq("mid_miso", 32'(miso), 32'd1);
        rst = 1'b1;
        @(negedge sys_clk);
        check_eq("mrst_miso", 32'(miso), 32'd0);
        check_eq("mrst_d_out", 32'(d_out), 32'h00);
        check_eq("mrst_read_en", 32'(read_en), 32'd0);
        check_eq("mrst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge sys_clk);
        cs  = 1'b1;
        rst = 1'b0;
        repeat (4) @(negedge sys_clk);
        check_eq("mrst_idle_busy", 32'(busy), 32'd0);

        // 4-bit frame
        t_size = 4'd4;
        d_in   = 8'h0B;
        base   = re_cnt;
        spi_xfer(4, 4, 0, 8'h09, 1'b1);
        check_eq("f4_master_rx", 32'(m_rx), 32'h0B);
        check_eq("f4_d_out", 32'(d_out), 32'h09);
        check_eq("f4_pulses", 32'(re_cnt - base), 32'd1);

        // Abort after 5 bits
        t_size = 4'd8;
        d_in   = 8'h00;
        base   = re_cnt;
        spi_xfer(8, 5, 0, 8'hFF, 1'b1);
        check_eq("abort_pulses", 32'(re_cnt - base), 32'd0);
        check_eq("abort_d_out", 32'(d_out), 32'h09);
        check_eq("abort_busy", 32'(busy), 32'd0);
        spi_xfer(8, 8, 0, 8'h81, 1'b1);
        check_eq("post_abort_d_out", 32'(d_out), 32'h81);

        // Out-of-range sizes fall back to 8 bits
        t_size = 4'd0;
        d_in   = 8'hC3;
        spi_xfer(8, 8, 0, 8'h5A, 1'b1);
        check_eq("ts0_d_out", 32'(d_out), 32'h5A);
        check_eq("ts0_master_rx", 32'(m_rx), 32'hC3);
        t_size = 4'd12;
        d_in   = 8'h3C;
        base   = re_cnt;
        spi_xfer(8, 8, 0, 8'h5A, 1'b1);
        check_eq("ts12_master_rx", 32'(m_rx), 32'h3C);
        check_eq("ts12_pulses", 32'(re_cnt - base), 32'd1);

        // Extra clocks after the last bit are ignored
        t_size = 4'd8;
        d_in   = 8'h97;
        base   = re_cnt;
        spi_xfer(8, 8, 3, 8'h3C, 1'b1);
        check_eq("extra_master_rx", 32'(m_rx), 32'h97);
        check_eq("extra_miso_hold", 32'(m_ex), 32'h7);
        check_eq("extra_pulses", 32'(re_cnt - base), 32'd1);
        check_eq("extra_d_out", 32'(d_out), 32'h3C);

`ifdef SPI_S_OVERRUN_EN
        d_in = 8'h00;
        spi_xfer(8, 8, 0, 8'h11, 1'b0);
        spi_xfer(8, 8, 0, 8'h22, 1'b0);
        check_eq("ovr_d_out", 32'(d_out), 32'h11);
        check_eq("ovr_flag", 32'(overrun), 32'd1);
        check_eq("ovr_read_en", 32'(read_en), 32'd1);
        rd_ack = 1'b1;
        @(negedge sys_clk);
        rd_ack = 1'b0;
        @(negedge sys_clk);
        check_eq("ack_read_en", 32'(read_en), 32'd0);
        check_eq("ack_overrun", 32'(overrun), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
